// File: rtl/carregador_pkg.sv
// carregador_pkg
// Shared definitions for the instruction loader: FSM state encoding,
// load size limits and the quantity clamp helper.
package carregador_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RECEBE  = 2'd1,
    ESCREVE = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam int MAX_PALAVRAS      = 256;
  localparam int BYTES_POR_PALAVRA = 4;

  // The memory holds 256 words; larger requests are clamped so the address
  // never wraps past 255.
  function automatic logic [8:0] limita_quantidade(input logic [8:0] q);
    if (q > 9'(MAX_PALAVRAS)) return 9'(MAX_PALAVRAS);
    else                      return q;
  endfunction

endpackage

// File: rtl/carregador_instrucao_montador_palavra.sv
// montador_palavra
// Assembles bytes little-endian into a 32-bit word.
// Ports:
//   clock, reset          : clock and asynchronous active-high reset
//   i_aceita              : byte accepted this cycle (valid && ready)
//   i_byte                : accepted byte
//   i_limpa               : restart assembly at byte 0
//   o_palavra             : current word with the incoming byte merged in
//   o_palavra_completa    : high while the fourth byte is being accepted
module montador_palavra
  import carregador_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_aceita,
  input  logic [7:0]  i_byte,
  input  logic        i_limpa,
  output logic [31:0] o_palavra,
  output logic        o_palavra_completa
);

  logic [1:0]  r_contador;
  logic [31:0] r_palavra;
  logic [31:0] w_palavra;

  // The merged value lets the caller capture the full word on the same edge
  // that accepts the last byte.
  always_comb begin
    w_palavra = r_palavra;
    w_palavra[8*r_contador +: 8] = i_byte;
  end

  assign o_palavra          = w_palavra;
  assign o_palavra_completa = i_aceita && (r_contador == 2'(BYTES_POR_PALAVRA - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contador <= 2'd0;
      r_palavra  <= 32'd0;
    end else if (i_limpa) begin
      r_contador <= 2'd0;
      r_palavra  <= 32'd0;
    end else if (i_aceita) begin
      // Counter wraps 3 -> 0 on its own, ready for the next word.
      r_contador <= r_contador + 2'd1;
      r_palavra  <= w_palavra;
    end
  end

endmodule

// File: rtl/carregador_instrucao.sv
// carregador_instrucao
// Streams bytes from the host into instruction memory, one 32-bit word per
// write, at consecutive addresses starting at 0. Keeps the CPU in reset
// until the first load completes and during any load.
// Handshake: a byte moves on a rising edge where byte_valido && byte_pronto;
// byte_pronto is only high in RECEBE, so bytes offered elsewhere stay pending.
// Ports:
//   clock, reset         : clock, asynchronous active-high reset
//   inicio, quantidade   : start pulse and word count (sampled when idle)
//   byte_valido/dado     : upstream byte stream; byte_pronto is our ready
//   escrita_*            : instruction memory write port (registered)
//   ocupado, concluido   : load in progress / one-cycle completion pulse
//   soma                 : XOR of all words written by the current/last load
//   segura_cpu           : CPU reset request
//   estado_dbg           : current FSM state for observation
module carregador_instrucao
  import carregador_pkg::*;
#(
  parameter int LARGURA_ENDERECO = 8,
  parameter int LARGURA_DADO     = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inicio,
  input  logic [8:0]                  quantidade,
  input  logic                        byte_valido,
  input  logic [7:0]                  byte_dado,
  output logic                        byte_pronto,
  output logic                        escrita_habilita,
  output logic [LARGURA_ENDERECO-1:0] escrita_endereco,
  output logic [LARGURA_DADO-1:0]     escrita_dado,
  output logic                        ocupado,
  output logic                        concluido,
  output logic [31:0]                 soma,
  output logic                        segura_cpu,
  output logic [1:0]                  estado_dbg
);

  estado_t                     r_estado;
  logic [8:0]                  r_quantidade;
  logic [8:0]                  r_contador_palavra;
  logic [31:0]                 r_soma;
  logic                        r_byte_pronto;
  logic                        r_escrita_habilita;
  logic [LARGURA_ENDERECO-1:0] r_escrita_endereco;
  logic [LARGURA_DADO-1:0]     r_escrita_dado;
  logic                        r_ocupado;
  logic                        r_concluido;
  logic                        r_segura_cpu;
  logic                        r_ja_concluiu;

  logic                        w_aceita;
  logic                        w_limpa;
  logic [31:0]                 w_palavra;
  logic                        w_palavra_completa;
  logic [8:0]                  w_quantidade_limitada;
  logic [8:0]                  w_contador_prox;

  assign w_aceita              = byte_valido && r_byte_pronto;
  assign w_limpa               = (r_estado == OCIOSO) && inicio;
  assign w_quantidade_limitada = limita_quantidade(quantidade);
  assign w_contador_prox       = r_contador_palavra + 9'd1;

  montador_palavra u_montador (
    .clock              (clock),
    .reset              (reset),
    .i_aceita           (w_aceita),
    .i_byte             (byte_dado),
    .i_limpa            (w_limpa),
    .o_palavra          (w_palavra),
    .o_palavra_completa (w_palavra_completa)
  );

  // Outputs are registered: each transition also loads the values the
  // destination state must present.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado           <= OCIOSO;
      r_quantidade       <= 9'd0;
      r_contador_palavra <= 9'd0;
      r_soma             <= 32'd0;
      r_byte_pronto      <= 1'b0;
      r_escrita_habilita <= 1'b0;
      r_escrita_endereco <= '0;
      r_escrita_dado     <= '0;
      r_ocupado          <= 1'b0;
      r_concluido        <= 1'b0;
      r_segura_cpu       <= 1'b1;
      r_ja_concluiu      <= 1'b0;
    end else begin
      r_concluido <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (inicio) begin
            r_quantidade       <= w_quantidade_limitada;
            r_contador_palavra <= 9'd0;
            r_soma             <= 32'd0;
            if (w_quantidade_limitada == 9'd0) begin
              r_estado     <= FIM;
              r_concluido  <= 1'b1;
              r_segura_cpu <= !r_ja_concluiu;
            end else begin
              r_estado      <= RECEBE;
              r_byte_pronto <= 1'b1;
              r_ocupado     <= 1'b1;
              r_segura_cpu  <= 1'b1;
            end
          end
        end
        RECEBE: begin
          if (w_palavra_completa) begin
            r_estado           <= ESCREVE;
            r_byte_pronto      <= 1'b0;
            r_escrita_habilita <= 1'b1;
            r_escrita_endereco <= r_contador_palavra[LARGURA_ENDERECO-1:0];
            r_escrita_dado     <= w_palavra;
          end
        end
        ESCREVE: begin
          r_escrita_habilita <= 1'b0;
          r_soma             <= r_soma ^ r_escrita_dado;
          r_contador_palavra <= w_contador_prox;
          if (w_contador_prox == r_quantidade) begin
            r_estado     <= FIM;
            r_concluido  <= 1'b1;
            r_ocupado    <= 1'b0;
            // Still held during the first FIM; released one cycle later.
            r_segura_cpu <= !r_ja_concluiu;
          end else begin
            r_estado      <= RECEBE;
            r_byte_pronto <= 1'b1;
          end
        end
        FIM: begin
          r_estado      <= OCIOSO;
          r_ja_concluiu <= 1'b1;
          r_segura_cpu  <= 1'b0;
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign byte_pronto      = r_byte_pronto;
  assign escrita_habilita = r_escrita_habilita;
  assign escrita_endereco = r_escrita_endereco;
  assign escrita_dado     = r_escrita_dado;
  assign ocupado          = r_ocupado;
  assign concluido        = r_concluido;
  assign soma             = r_soma;
  assign segura_cpu       = r_segura_cpu;
  assign estado_dbg       = r_estado;

endmodule
